// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - two-port command arbiter in front of a single-port RAM
//
// Two requesters (port 0: SPI slave rx path, port 1: local host) issue
// {cmd[1:0], payload} words: 00 write addr, 01 write data, 10 read addr,
// 11 read data. An address command locks the RAM to its sender until the
// matching data command completes (or a timeout releases the lock).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_cmd / reqN_valid      command word and its valid from requester N
//   reqN_ready                 word accepted on valid & ready
//   reqN_rd_data/reqN_rd_valid read data returned to requester N (1-cycle pulse)
//   ram_din / ram_rx_valid     forwarded word and its 1-cycle strobe
//   ram_dout / ram_tx_valid    RAM read data and its valid
//   owner, busy                current lock owner, state != IDLE
//   err                        1-cycle pulse on dropped word or timeout
module spi_ram_arbiter #(
    parameter int ADDR_SIZE    = 8,
    parameter int LOCK_TIMEOUT = 64,
    parameter int RD_TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] req0_cmd,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    output logic [ADDR_SIZE-1:0] req0_rd_data,
    output logic                 req0_rd_valid,
    input  logic [ADDR_SIZE+1:0] req1_cmd,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    output logic [ADDR_SIZE-1:0] req1_rd_data,
    output logic                 req1_rd_valid,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 owner,
    output logic                 busy,
    output logic                 err
);

    localparam int CW     = ADDR_SIZE + 2;
    localparam int TMAX   = (LOCK_TIMEOUT > RD_TIMEOUT) ? LOCK_TIMEOUT : RD_TIMEOUT;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;

    // Timer value seen in the last waiting cycle before expiry.
    localparam logic [TW-1:0] LOCK_LIM = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] RD_LIM   = TW'(RD_TIMEOUT - 1);

    logic [1:0]    state;
    logic          rr;
    logic          exp_rd;     // 1: lock expects 11 (read data), 0: expects 01
    logic [TW-1:0] timer;

    logic          ready0;
    logic          ready1;
    logic          acc0;
    logic          acc1;
    logic          acc;
    logic          acc_port;
    logic [CW-1:0] acc_word;
    logic [1:0]    acc_op;
    logic          fwd;

    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        case (state)
            S_IDLE: begin
                // Contention resolved by the round-robin pointer.
                ready0 = req0_valid && (!req1_valid || !rr);
                ready1 = req1_valid && (!req0_valid ||  rr);
            end
            S_HOLD: begin
                ready0 = !owner;
                ready1 =  owner;
            end
            default: begin
                ready0 = 1'b0;
                ready1 = 1'b0;
            end
        endcase
        // Keep ready low while reset is asserted so no output is live in reset.
        if (!rst_n) begin
            ready0 = 1'b0;
            ready1 = 1'b0;
        end
    end

    assign req0_ready = ready0;
    assign req1_ready = ready1;

    // At most one port can be accepted in any cycle.
    assign acc0     = req0_valid && ready0;
    assign acc1     = req1_valid && ready1;
    assign acc      = acc0 || acc1;
    assign acc_port = acc1;
    assign acc_word = acc1 ? req1_cmd : req0_cmd;
    assign acc_op   = acc_word[CW-1:CW-2];

    // Address words are always forwarded; data words only when they match
    // the lock's expectation. Orphans and mismatches are dropped.
    always_comb begin
        fwd = 1'b0;
        if (acc) begin
            if (state == S_IDLE) begin
                fwd = !acc_op[0];
            end else if (state == S_HOLD) begin
                fwd = !acc_op[0] || (acc_op[1] == exp_rd);
            end
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
        end else begin
            ram_rx_valid <= fwd;
            if (fwd) begin
                ram_din <= acc_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rr            <= 1'b0;
            owner         <= 1'b0;
            exp_rd        <= 1'b0;
            timer         <= '0;
            err           <= 1'b0;
            req0_rd_data  <= '0;
            req0_rd_valid <= 1'b0;
            req1_rd_data  <= '0;
            req1_rd_valid <= 1'b0;
        end else begin
            err           <= 1'b0;
            req0_rd_valid <= 1'b0;
            req1_rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acc) begin
                        if (!acc_op[0]) begin
                            owner  <= acc_port;
                            exp_rd <= acc_op[1];
                            state  <= S_HOLD;
                            timer  <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (acc) begin
                        // Any acceptance restarts the lock timer, even in
                        // the cycle the timer would otherwise expire.
                        timer <= '0;
                        if (!acc_op[0]) begin
                            exp_rd <= acc_op[1];
                        end else if (acc_op[1] == exp_rd) begin
                            if (exp_rd) begin
                                state <= S_WAIT_RD;
                            end else begin
                                state <= S_IDLE;
                                rr    <= ~owner;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (timer == LOCK_LIM) begin
                        state <= S_IDLE;
                        rr    <= ~owner;
                        err   <= 1'b1;
                        timer <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_RD: begin
                    if (ram_tx_valid) begin
                        if (owner) begin
                            req1_rd_data  <= ram_dout;
                            req1_rd_valid <= 1'b1;
                        end else begin
                            req0_rd_data  <= ram_dout;
                            req0_rd_valid <= 1'b1;
                        end
                        state <= S_IDLE;
                        rr    <= ~owner;
                        timer <= '0;
                    end else if (timer == RD_LIM) begin
                        state <= S_IDLE;
                        rr    <= ~owner;
                        err   <= 1'b1;
                        timer <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - self-checking bench for spi_ram_arbiter
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] req0_cmd = '0;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req0_rd_data;
    logic       req0_rd_valid;
    logic [9:0] req1_cmd = '0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] req1_rd_data;
    logic       req1_rd_valid;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = '0;
    logic       ram_tx_valid = 1'b0;
    logic       owner;
    logic       busy;
    logic       err;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;

    logic [9:0] rxq[$];
    logic [7:0] rd0q[$];
    logic [7:0] rd1q[$];

    spi_ram_arbiter #(.ADDR_SIZE(8), .LOCK_TIMEOUT(64), .RD_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_cmd(req0_cmd), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rd_data(req0_rd_data), .req0_rd_valid(req0_rd_valid),
        .req1_cmd(req1_cmd), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rd_data(req1_rd_data), .req1_rd_valid(req1_rd_valid),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
        .owner(owner), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: pop expectations whenever the DUT strobes an output.
    always @(negedge clk) begin
        if (ram_rx_valid) begin
            chk("rx_expected", 32'(rxq.size() != 0), 1);
            if (rxq.size() != 0) chk("ram_din", 32'(ram_din), 32'(rxq.pop_front()));
        end
        if (req0_rd_valid) begin
            chk("rd0_expected", 32'(rd0q.size() != 0), 1);
            if (rd0q.size() != 0) chk("req0_rd_data", 32'(req0_rd_data), 32'(rd0q.pop_front()));
        end
        if (req1_rd_valid) begin
            chk("rd1_expected", 32'(rd1q.size() != 0), 1);
            if (rd1q.size() != 0) chk("req1_rd_data", 32'(req1_rd_data), 32'(rd1q.pop_front()));
        end
        if (err) err_seen++;
    end

    // One cycle of stimulus: er0/er1 say which port the bench expects to be
    // accepted, fwd whether that word must reach the RAM, eerr whether err pulses.
    task automatic drive(input logic v0, input logic [9:0] c0, input logic v1, input logic [9:0] c1,
                         input logic er0, input logic er1, input logic fwd, input logic eerr,
                         input string tag);
        @(negedge clk);
        req0_valid = v0; req0_cmd = c0;
        req1_valid = v1; req1_cmd = c1;
        #1;
        if (v0) chk({tag, "_ready0"}, 32'(req0_ready), 32'(er0));
        if (v1) chk({tag, "_ready1"}, 32'(req1_ready), 32'(er1));
        if (fwd) rxq.push_back(er1 ? c1 : c0);
        @(posedge clk);
        #1;
        chk({tag, "_rx_valid"}, 32'(ram_rx_valid), 32'(fwd));
        chk({tag, "_err"}, 32'(err), 32'(eerr));
    endtask

    task automatic idle1();
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_return(input logic [7:0] d, input logic port, input string tag);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        ram_tx_valid = 1'b1; ram_dout = d;
        if (port) rd1q.push_back(d); else rd0q.push_back(d);
        @(posedge clk);
        #1;
        chk({tag, "_rd0_valid"}, 32'(req0_rd_valid), 32'(!port));
        chk({tag, "_rd1_valid"}, 32'(req1_rd_valid), 32'(port));
        chk({tag, "_busy"}, 32'(busy), 0);
        @(negedge clk);
        ram_tx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int first;

        // Reset state
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_din", 32'(ram_din), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Both valid at reset exit: P0 first, P1 stalls during P0 lock, then wins
        drive(1, 10'h011, 1, 10'h233, 1, 0, 1, 0, "arb_a0");
        chk("arb_owner0", 32'(owner), 0);
        drive(1, 10'h122, 1, 10'h233, 1, 0, 1, 0, "arb_d0");
        drive(1, 10'h044, 1, 10'h233, 0, 1, 1, 0, "arb_p1_wins");
        chk("arb_owner1", 32'(owner), 1);
        drive(1, 10'h044, 1, 10'h300, 0, 1, 1, 0, "arb_p1_rd");
        drive(1, 10'h044, 0, 10'h000, 0, 0, 0, 0, "arb_wait_rd_stall");
        chk("arb_wait_busy", 32'(busy), 1);
        rd_return(8'h5C, 1, "arb_ret1");
        drive(1, 10'h044, 0, 10'h000, 1, 0, 1, 0, "arb_p0_a");
        drive(1, 10'h145, 0, 10'h000, 1, 0, 1, 0, "arb_p0_d");

        // Simple write
        drive(1, 10'h0FA, 0, 10'h000, 1, 0, 1, 0, "wr_addr");
        chk("wr_busy_hold", 32'(busy), 1);
        drive(1, 10'h1AF, 0, 10'h000, 1, 0, 1, 0, "wr_data");
        idle1();
        chk("wr_busy_after", 32'(busy), 0);

        // Read on P0, P1 rd_data unaffected
        drive(1, 10'h2FA, 0, 10'h000, 1, 0, 1, 0, "rd_addr");
        drive(1, 10'h300, 0, 10'h000, 1, 0, 1, 0, "rd_data_cmd");
        rd_return(8'hAF, 0, "rd_ret0");
        chk("rd_p1_hold", 32'(req1_rd_data), 32'h5C);

        // Lock timeout on P1, then P0 served
        drive(0, 10'h000, 1, 10'h010, 0, 1, 1, 0, "to_addr");
        first = -1;
        for (int i = 1; i <= 80 && first < 0; i++) begin
            idle1();
            if (err) first = i;
            if (i == 63) chk("to_busy_63", 32'(busy), 1);
        end
        chk("to_cycle", 32'(first), 64);
        chk("to_busy_after", 32'(busy), 0);
        drive(1, 10'h020, 0, 10'h000, 1, 0, 1, 0, "to_p0_addr");
        drive(1, 10'h121, 0, 10'h000, 1, 0, 1, 0, "to_p0_data");

        // Orphan data in IDLE and wrong data command in HOLD
        drive(1, 10'h155, 0, 10'h000, 1, 0, 0, 1, "orphan");
        chk("orphan_busy", 32'(busy), 0);
        drive(1, 10'h066, 0, 10'h000, 1, 0, 1, 0, "wrong_addr");
        drive(1, 10'h300, 0, 10'h000, 1, 0, 0, 1, "wrong_cmd");
        chk("wrong_busy", 32'(busy), 1);
        drive(1, 10'h177, 0, 10'h000, 1, 0, 1, 0, "wrong_fix");

        // Read timeout: err after 8 cycles, rd_data unchanged
        drive(1, 10'h201, 0, 10'h000, 1, 0, 1, 0, "rto_addr");
        drive(1, 10'h300, 0, 10'h000, 1, 0, 1, 0, "rto_cmd");
        first = -1;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            idle1();
            if (err) first = i;
        end
        chk("rto_cycle", 32'(first), 8);
        chk("rto_busy", 32'(busy), 0);
        chk("rto_rd0_hold", 32'(req0_rd_data), 32'hAF);

        // Reset in the middle of WAIT_RD
        drive(1, 10'h202, 0, 10'h000, 1, 0, 1, 0, "rst_addr");
        drive(1, 10'h300, 0, 10'h000, 1, 0, 1, 0, "rst_cmd");
        idle1();
        chk("rst_pre_busy", 32'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_cmd = 10'h099;
        #1;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_ready0", 32'(req0_ready), 0);
        chk("mrst_rd0", 32'(req0_rd_data), 0);
        chk("mrst_rd1", 32'(req1_rd_data), 0);
        chk("mrst_din", 32'(ram_din), 0);
        chk("mrst_owner", 32'(owner), 0);
        repeat (2) @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        ram_tx_valid = 1'b1; ram_dout = 8'hEE;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_rd", 32'(req0_rd_valid | req1_rd_valid), 0);
        end
        ram_tx_valid = 1'b0;
        chk("post_rst_busy", 32'(busy), 0);

        repeat (3) @(negedge clk);
        chk("rxq_empty", 32'(rxq.size()), 0);
        chk("rd0q_empty", 32'(rd0q.size()), 0);
        chk("rd1q_empty", 32'(rd1q.size()), 0);
        chk("err_pulses", 32'(err_seen), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
